// File: rtl/reg_wb_arbiter.sv
// Two writeback FIFOs (ALU, load unit) sharing the register-file write port via round-robin.
// Optional feature macro: RF_WB_X0_DROP_EN (granted entries addressed to x0 are popped but not written).
module reg_wb_arbiter #(
  parameter int LOG_REG_CNT = 5,
  parameter int REG_LEN     = 32,
  parameter int DEPTH       = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [LOG_REG_CNT-1:0] req0_addr,
  input  logic [REG_LEN-1:0]     req0_val,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [LOG_REG_CNT-1:0] req1_addr,
  input  logic [REG_LEN-1:0]     req1_val,
  output logic                   write,
  output logic [LOG_REG_CNT-1:0] write_addr,
  output logic [REG_LEN-1:0]     write_val,
  output logic                   idle
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [LOG_REG_CNT-1:0] addr_mem_r [2][DEPTH];
  logic [REG_LEN-1:0]     val_mem_r  [2][DEPTH];
  logic [PW-1:0]          rd_ptr_r   [2];
  logic [PW-1:0]          wr_ptr_r   [2];
  logic [CW-1:0]          count_r    [2];
  logic                   last_grant_r;
  logic                   write_r;
  logic [LOG_REG_CNT-1:0] write_addr_r;
  logic [REG_LEN-1:0]     write_val_r;

  logic [1:0]             in_valid_s;
  logic [1:0]             in_ready_s;
  logic [1:0]             push_s;
  logic [1:0]             pop_s;
  logic [1:0]             head_valid_s;
  logic [LOG_REG_CNT-1:0] in_addr_s [2];
  logic [REG_LEN-1:0]     in_val_s  [2];
  logic                   grant_s;
  logic                   grant_any_s;
  logic [LOG_REG_CNT-1:0] head_addr_s;
  logic [REG_LEN-1:0]     head_val_s;

  assign in_valid_s   = {req1_valid, req0_valid};
  assign in_addr_s[0] = req0_addr;
  assign in_addr_s[1] = req1_addr;
  assign in_val_s[0]  = req0_val;
  assign in_val_s[1]  = req1_val;
  assign req0_ready   = in_ready_s[0];
  assign req1_ready   = in_ready_s[1];
  assign write        = write_r;
  assign write_addr   = write_addr_r;
  assign write_val    = write_val_r;
  assign idle         = (count_r[0] == '0) && (count_r[1] == '0) && !write_r;

  // Handshake, round-robin grant and head selection; ready never sees a same-cycle pop.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      in_ready_s[n]   = (count_r[n] != FULL);
      head_valid_s[n] = (count_r[n] != '0);
      push_s[n]       = rdy & in_valid_s[n] & in_ready_s[n];
    end
    grant_any_s = |head_valid_s;
    case (head_valid_s)
      2'b01:   grant_s = 1'b0;
      2'b10:   grant_s = 1'b1;
      2'b11:   grant_s = ~last_grant_r;
      default: grant_s = 1'b0;
    endcase
    pop_s = 2'b00;
    if (rdy && grant_any_s) begin
      pop_s[grant_s] = 1'b1;
    end else begin
      pop_s = 2'b00;
    end
    head_addr_s = addr_mem_r[grant_s][rd_ptr_r[grant_s]];
    head_val_s  = val_mem_r[grant_s][rd_ptr_r[grant_s]];
  end

  // FIFO storage; contents are don't-care until counted valid, so no reset.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (push_s[n]) begin
        addr_mem_r[n][wr_ptr_r[n]] <= in_addr_s[n];
        val_mem_r[n][wr_ptr_r[n]]  <= in_val_s[n];
      end
    end
  end

  // Pointers, counts, grant history and the registered write port; rdy=0 holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 2; n++) begin
        rd_ptr_r[n] <= '0;
        wr_ptr_r[n] <= '0;
        count_r[n]  <= '0;
      end
      last_grant_r <= 1'b1;
      write_r      <= 1'b0;
      write_addr_r <= '0;
      write_val_r  <= '0;
    end else if (rdy) begin
      for (int n = 0; n < 2; n++) begin
        if (push_s[n]) wr_ptr_r[n] <= wr_ptr_r[n] + PW'(1);
        if (pop_s[n])  rd_ptr_r[n] <= rd_ptr_r[n] + PW'(1);
        count_r[n] <= count_r[n] + CW'(push_s[n]) - CW'(pop_s[n]);
      end
      if (grant_any_s) begin
        last_grant_r <= grant_s;
`ifdef RF_WB_X0_DROP_EN
        if (head_addr_s == '0) begin
          write_r <= 1'b0;
        end else begin
          write_r      <= 1'b1;
          write_addr_r <= head_addr_s;
          write_val_r  <= head_val_s;
        end
`else
        write_r      <= 1'b1;
        write_addr_r <= head_addr_s;
        write_val_r  <= head_val_s;
`endif
      end else begin
        write_r <= 1'b0;
      end
    end
  end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
Shares the register file's single write port between two writeback requesters: requester 0 is the ALU and requester 1 is the load unit.
- Each requester has its own DEPTH-entry FIFO with a valid/ready handshake.
- A round-robin arbiter pops one FIFO head per cycle and drives registered write/write_addr/write_val into the register file.
- Sits between the execute/memory stages and the register file.

Parameters:
LOG_REG_CNT, 5, width of register address
REG_LEN, 32, width of register value
DEPTH, 2, entries per requester FIFO (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global ready; 0 freezes all state
req0_valid  in  1  ALU writeback request
req0_ready  out  1  FIFO 0 can accept
req0_addr  in  LOG_REG_CNT  destination register
req0_val  in  REG_LEN  value to write
req1_valid  in  1  load-unit writeback request
req1_ready  out  1  FIFO 1 can accept
req1_addr  in  LOG_REG_CNT  destination register
req1_val  in  REG_LEN  value to write
write  out  1  register file write enable (registered)
write_addr  out  LOG_REG_CNT  register file write address (registered)
write_val  out  REG_LEN  register file write data (registered)
idle  out  1  both FIFOs empty and write==0

Behaviour:
- Reset (rst=1 at posedge): both FIFOs empty, pointers and counts 0, write=0, write_addr=0, write_val=0, last_grant=1 (requester 0 wins first tie).
- Reset mid-operation discards all queued entries; no write pulse in the following cycle.
- reqN_ready = (countN != DEPTH), combinational from current count only. A pop in the same cycle does not free a slot early.
- Push into FIFO N at a posedge with rdy=1, reqN_valid=1, reqN_ready=1. If valid=1 while ready=0, the request is not taken and the requester holds it.
- rdy=0 at a posedge: no push, no pop, all registers (including write, write_addr, write_val, last_grant) hold.
  - A pending write pulse therefore stays asserted until the next rdy=1 edge, where the register file commits it exactly once.
- Arbitration at each posedge with rdy=1:
  - Neither head valid: write<=0.
  - One head valid: grant it.
  - Both heads valid: grant the requester != last_grant.
  - On a grant: pop that FIFO, write<=1, write_addr/write_val<=head entry, last_grant<=granted index.
- No FIFO bypass. Timing for a push at edge E0:
  - E1: the entry is popped (if granted).
  - Cycle after E1: write=1.
  - E2: the register file commits.
  - Minimum request-to-commit latency is 2 edges.
- Throughput: 1 write per cycle total; a lone requester streams at 1/cycle.
- Push and pop on the same FIFO in the same cycle are legal. The count is unchanged; the pointers advance mod DEPTH.
- Ordering: FIFO order within a requester is preserved. Order across requesters follows grant order only; hazard tracking on same-address writes is handled upstream.
- idle is combinational.

Optional Feature:
Macro: RF_WB_X0_DROP_EN
- Defined: a granted entry with addr==0 is popped, but write<=0 and write_addr/write_val hold their previous values, so register x0 is never written. The grant still counts for round-robin.
- Undefined: addr==0 entries are written like any other (write<=1, write_addr=0).

Test Plan:
- Reset, then req0 push (addr=5, val=0xDEADBEEF) -> write=1, write_addr=5, write_val=0xDEADBEEF in the cycle after the pop edge; write=0 on the following cycle; idle returns to 1.
- Both requesters push every cycle for 6 cycles -> grants alternate 0,1,0,1,... starting with 0. Both readys drop once the FIFOs fill. Every value is written exactly once, with FIFO order preserved per requester.
- Fill FIFO 1 (DEPTH=2) while req0 streams -> req1_ready=0 with count=2. A push attempted in that cycle is not taken and must be re-presented. Ready returns after a pop.
- rdy=0 for 3 cycles while write=1 (addr=7, val=0x11) and both FIFOs hold entries -> all outputs and readys frozen, no pops. On rdy=1 the register file commits 0x11 to x7 once, then arbitration resumes.
- rst asserted while FIFOs hold 3 entries -> next cycle write=0, idle=1, readys=1; no stale entries are ever written.
- req0 addr=0 val=0x1234: with RF_WB_X0_DROP_EN -> write stays 0 and register x0 reads 0; without -> write=1, write_addr=0.
